// File: rtl/tc_sram_arb_pkg.sv
// tc_sram_arb_pkg: shared types and round-robin pick helper for the tc_sram arbiter
package tc_sram_arb_pkg;
  localparam int MaxReq = 64;
  localparam int MaxIdxWidth = 6;
  typedef struct packed {
    logic                   valid;
    logic [MaxIdxWidth-1:0] idx;
    logic                   we;
  } rsp_entry_t;
  typedef struct packed {
    logic                   found;
    logic [MaxIdxWidth-1:0] idx;
  } rr_pick_t;
  function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] valid, input logic [MaxIdxWidth-1:0] ptr, input int n);
    rr_pick_t r;
    int j;
    r = '0;
    for (int i = 0; i < MaxReq; i++) begin
      j = int'(ptr) + i;
      j = (j >= n) ? j - n : j;
      if (i < n && !r.found && valid[j]) begin
        r.found = 1'b1;
        r.idx = j[MaxIdxWidth-1:0];
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/tc_sram_rsp_pipe.sv
// tc_sram_rsp_pipe: Latency-deep shift register tracking in-flight SRAM accesses
module tc_sram_rsp_pipe
  import tc_sram_arb_pkg::*;
#(
  parameter int Latency = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  rsp_entry_t push,
  output rsp_entry_t head
);
  rsp_entry_t stage [Latency];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Latency; i++) stage[i] <= '0;
    end else begin
      stage[0] <= push;
      for (int i = 1; i < Latency; i++) stage[i] <= stage[i-1];
    end
  end
  assign head = stage[Latency-1];
endmodule

// File: rtl/tc_sram_rr_arbiter.sv
// tc_sram_rr_arbiter: round-robin share of one single-port tc_sram among NumReq requesters
module tc_sram_rr_arbiter
  import tc_sram_arb_pkg::*;
#(
  parameter int NumReq    = 4,
  parameter int NoWords   = 1024,
  parameter int DataWidth = 32,
  parameter int ByteWidth = 8,
  parameter int Latency   = 1,
  localparam int AddrWidth = (NoWords > 1) ? $clog2(NoWords) : 1,
  localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  input  logic [NumReq-1:0]                   req_we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    req_wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]      req_be_i,
  output logic [NumReq-1:0]                   rsp_valid_o,
  output logic [NumReq-1:0][DataWidth-1:0]    rsp_rdata_o,
  output logic                                sram_req_o,
  output logic                                sram_we_o,
  output logic [AddrWidth-1:0]                sram_addr_o,
  output logic [DataWidth-1:0]                sram_wdata_o,
  output logic [BeWidth-1:0]                  sram_be_o,
  input  logic [DataWidth-1:0]                sram_rdata_i
);
  logic [MaxIdxWidth-1:0] ptr_q;
  logic [MaxReq-1:0]      valid_ext;
  logic [IdxWidth-1:0]    grant;
  logic                   accept;
  rr_pick_t               pick;
  rsp_entry_t             push;
  rsp_entry_t             head;
  always_comb begin
    valid_ext = '0;
    valid_ext[NumReq-1:0] = req_valid_i;
  end
  assign pick         = rr_pick(valid_ext, ptr_q, NumReq);
  assign grant        = pick.idx[IdxWidth-1:0];
  assign accept       = pick.found && !rst_i;
  assign req_ready_o  = accept ? NumReq'(1) << grant : '0;
  assign sram_req_o   = accept;
  assign sram_we_o    = accept && req_we_i[grant];
  assign sram_addr_o  = accept ? req_addr_i[grant] : '0;
  assign sram_wdata_o = accept ? req_wdata_i[grant] : '0;
  assign sram_be_o    = accept ? req_be_i[grant] : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else if (accept) ptr_q <= (pick.idx == MaxIdxWidth'(NumReq - 1)) ? '0 : pick.idx + 1'b1;
  end
  assign push = '{valid: accept, idx: pick.idx, we: sram_we_o};
  tc_sram_rsp_pipe #(.Latency(Latency)) u_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .head  (head)
  );
  for (genvar g = 0; g < NumReq; g++) begin : g_lane
    assign rsp_valid_o[g] = head.valid && !rst_i && head.idx == MaxIdxWidth'(g);
    assign rsp_rdata_o[g] = (rsp_valid_o[g] && !head.we) ? sram_rdata_i : '0;
  end
endmodule

// File: tb/tb_tc_sram_rr_arbiter.sv
// tb_tc_sram_rr_arbiter: scoreboard bench for the arbiter at Latency 1 and 3
module tb_tc_sram_rr_arbiter;
  typedef struct {
    int          due;
    logic [3:0]  lane;
    logic [31:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic [1:0] rst;
  logic [3:0] v [2];
  logic [3:0] we [2];
  logic [3:0] rdy [2];
  logic [3:0] rv [2];
  logic [3:0][9:0] addr [2];
  logic [3:0][31:0] wd [2];
  logic [3:0][31:0] rd [2];
  logic [3:0][3:0] be [2];
  logic sreq [2];
  logic swe [2];
  logic [9:0] saddr [2];
  logic [31:0] swd [2];
  logic [3:0] sbe [2];
  logic [31:0] srd0, srd1;
  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  logic [31:0] rb [3];
  exp_t qa [$];
  exp_t qb [$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int acc [4];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  tc_sram_rr_arbiter #(.NumReq(4), .NoWords(1024), .DataWidth(32), .ByteWidth(8), .Latency(1)) dut_a (
    .clk_i(clk), .rst_i(rst[0]), .req_valid_i(v[0]), .req_ready_o(rdy[0]), .req_we_i(we[0]),
    .req_addr_i(addr[0]), .req_wdata_i(wd[0]), .req_be_i(be[0]), .rsp_valid_o(rv[0]), .rsp_rdata_o(rd[0]),
    .sram_req_o(sreq[0]), .sram_we_o(swe[0]), .sram_addr_o(saddr[0]), .sram_wdata_o(swd[0]),
    .sram_be_o(sbe[0]), .sram_rdata_i(srd0)
  );
  tc_sram_rr_arbiter #(.NumReq(4), .NoWords(1024), .DataWidth(32), .ByteWidth(8), .Latency(3)) dut_b (
    .clk_i(clk), .rst_i(rst[1]), .req_valid_i(v[1]), .req_ready_o(rdy[1]), .req_we_i(we[1]),
    .req_addr_i(addr[1]), .req_wdata_i(wd[1]), .req_be_i(be[1]), .rsp_valid_o(rv[1]), .rsp_rdata_o(rd[1]),
    .sram_req_o(sreq[1]), .sram_we_o(swe[1]), .sram_addr_o(saddr[1]), .sram_wdata_o(swd[1]),
    .sram_be_o(sbe[1]), .sram_rdata_i(srd1)
  );
  always @(posedge clk) begin
    if (sreq[0]) begin
      if (swe[0]) begin
        for (int k = 0; k < 4; k++) begin
          if (sbe[0][k]) mem_a[saddr[0]][8*k+:8] <= swd[0][8*k+:8];
        end
      end else begin
        srd0 <= mem_a[saddr[0]];
      end
    end
  end
  always @(posedge clk) begin
    if (sreq[1]) begin
      if (swe[1]) begin
        for (int k = 0; k < 4; k++) begin
          if (sbe[1][k]) mem_b[saddr[1]][8*k+:8] <= swd[1][8*k+:8];
        end
      end else begin
        rb[0] <= mem_b[saddr[1]];
      end
    end
    rb[1] <= rb[0];
    rb[2] <= rb[1];
  end
  assign srd1 = rb[2];
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, act, req);
    end
  endtask
  task automatic mon(input int d);
    exp_t e;
    logic [3:0][31:0] er;
    if (|rv[d]) begin
      if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected dut%0d @cyc %0d: got valid %b required none", d, cyc, rv[d]);
      end else begin
        if (d == 0) e = qa.pop_front();
        else e = qb.pop_front();
        for (int k = 0; k < 4; k++) er[k] = e.lane[k] ? e.data : 32'h0;
        check("rsp_valid", 128'(rv[d]), 128'(e.lane));
        check("rsp_rdata", 128'(rd[d]), 128'(er));
        check("rsp_cycle", 128'(cyc), 128'(e.due));
      end
    end
  endtask
  always @(negedge clk) begin
    mon(0);
    mon(1);
  end
  task automatic drive(input int d, input logic [3:0] vv, input logic [3:0] wem, input logic [3:0] b,
                       input logic [9:0] a, input logic [31:0] w, input logic [3:0] er,
                       input logic [31:0] ed, input bit push);
    exp_t e;
    v[d] = vv;
    we[d] = wem;
    for (int k = 0; k < 4; k++) begin
      addr[d][k] = a;
      wd[d][k] = w;
      be[d][k] = b;
    end
    @(negedge clk);
    check("req_ready", 128'(rdy[d]), 128'(er));
    check("sram_req", 128'(sreq[d]), 128'(|er));
    check("sram_addr", 128'(saddr[d]), 128'((er != 0) ? a : 10'h0));
    check("sram_we", 128'(swe[d]), 128'(|(wem & er)));
    if (!push || rst[d]) check("rsp_quiet", 128'(rv[d]), 128'(0));
    if (d == 0) for (int k = 0; k < 4; k++) acc[k] += int'(rdy[0][k]);
    if (push && er != 0) begin
      e.due = cyc + ((d == 0) ? 1 : 3);
      e.lane = er;
      e.data = ed;
      if (d == 0) qa.push_back(e);
      else qb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 2'b11;
    for (int d = 0; d < 2; d++) begin
      v[d] = '0;
      we[d] = '0;
      addr[d] = '0;
      wd[d] = '0;
      be[d] = '0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) drive(0, 4'hF, 4'hF, 4'hF, 10'd100, 32'h0, 4'h0, 32'h0, 1'b1);
    rst[0] = 1'b0;
    for (int k = 0; k < 4; k++) acc[k] = 0;
    for (int i = 0; i < 8; i++) drive(0, 4'hF, 4'hF, 4'hF, 10'd100, 32'h0, 4'b0001 << (i % 4), 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) check($sformatf("fair_count%0d", k), 128'(acc[k]), 128'(2));
    drive(0, 4'b0100, 4'b0100, 4'hF, 10'h10, 32'hDEADBEEF, 4'b0100, 32'h0, 1'b1);
    drive(0, 4'b0010, 4'b0000, 4'hF, 10'h10, 32'h0, 4'b0010, 32'hDEADBEEF, 1'b1);
    drive(0, 4'b0000, 4'b0000, 4'h0, 10'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    drive(0, 4'b1000, 4'b1000, 4'hF, 10'd5, 32'h11223344, 4'b1000, 32'h0, 1'b1);
    drive(0, 4'b1000, 4'b1000, 4'b0101, 10'd5, 32'hAABBCCDD, 4'b1000, 32'h0, 1'b1);
    drive(0, 4'b1000, 4'b0000, 4'hF, 10'd5, 32'h0, 4'b1000, 32'h11BB33DD, 1'b1);
    drive(0, 4'b1001, 4'b0000, 4'hF, 10'd5, 32'h0, 4'b0001, 32'h11BB33DD, 1'b1);
    drive(0, 4'b1001, 4'b0000, 4'hF, 10'd5, 32'h0, 4'b1000, 32'h11BB33DD, 1'b1);
    drive(0, 4'b0000, 4'b0000, 4'h0, 10'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    drive(0, 4'b0000, 4'b0000, 4'h0, 10'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
    rst[1] = 1'b0;
    drive(1, 4'b0001, 4'b0001, 4'hF, 10'h20, 32'hA0A0A0A0, 4'b0001, 32'h0, 1'b1);
    drive(1, 4'b0010, 4'b0010, 4'hF, 10'h21, 32'hB1B1B1B1, 4'b0010, 32'h0, 1'b1);
    drive(1, 4'b0100, 4'b0100, 4'hF, 10'h22, 32'hC2C2C2C2, 4'b0100, 32'h0, 1'b1);
    drive(1, 4'b1000, 4'b1000, 4'hF, 10'h23, 32'hD3D3D3D3, 4'b1000, 32'h0, 1'b1);
    drive(1, 4'b0001, 4'b0000, 4'hF, 10'h20, 32'h0, 4'b0001, 32'hA0A0A0A0, 1'b1);
    drive(1, 4'b0010, 4'b0000, 4'hF, 10'h21, 32'h0, 4'b0010, 32'hB1B1B1B1, 1'b1);
    drive(1, 4'b0100, 4'b0000, 4'hF, 10'h22, 32'h0, 4'b0100, 32'hC2C2C2C2, 1'b1);
    drive(1, 4'b1000, 4'b0000, 4'hF, 10'h23, 32'h0, 4'b1000, 32'hD3D3D3D3, 1'b1);
    for (int i = 0; i < 4; i++) drive(1, 4'b0000, 4'b0000, 4'h0, 10'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    drive(1, 4'b0001, 4'b0000, 4'hF, 10'h20, 32'h0, 4'b0001, 32'h0, 1'b0);
    drive(1, 4'b0010, 4'b0000, 4'hF, 10'h21, 32'h0, 4'b0010, 32'h0, 1'b0);
    rst[1] = 1'b1;
    drive(1, 4'hF, 4'b0000, 4'hF, 10'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
    rst[1] = 1'b0;
    for (int i = 0; i < 4; i++) drive(1, 4'b0000, 4'b0000, 4'h0, 10'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
    drive(1, 4'hF, 4'b0000, 4'hF, 10'h20, 32'h0, 4'b0001, 32'hA0A0A0A0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1, 4'b0000, 4'b0000, 4'h0, 10'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    check("scoreboard_drained", 128'(qa.size() + qb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
